// File: rtl/struct_rr_merge_pkg.sv
// +--------------------------------------------------------------------------+
// | rr_merge_pkg : shared types and helpers for the struct_rr_merge block    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package rr_merge_pkg;

  localparam int NUM   = 5;
  localparam int DSIZE = 10;
  localparam int OP_W  = 4;
  localparam int CH_W  = $clog2(NUM);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DSIZE-1:0] data;
    logic [CH_W-1:0]  ch;
    logic             last;
  } rec_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_st_t;

  // Cyclic successor; NUM need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned num);
    return (cur == num - 1) ? 0 : cur + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/struct_rr_merge_rec_fifo.sv
// +--------------------------------------------------------------------------+
// | rec_fifo : synchronous FIFO of packed records with count, full, empty    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module rec_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign cnt_o   = cnt_q;
  // Head reads as zero when empty so the output record is clean after reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/struct_rr_merge.sv
// +--------------------------------------------------------------------------+
// | struct_rr_merge : N-to-1 round-robin record merger with optional packet  |
// |                   lock, feeding a registered output FIFO                 |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module struct_rr_merge #(
  parameter int NUM      = 5,
  parameter int DSIZE    = 10,
  parameter int OP_W     = 4,
  parameter int DEPTH    = 4,
  parameter int PKT_MODE = 0
) (
  input  logic                                 clock,
  input  logic                                 rst,
  input  logic [NUM-1:0]                       in_vld,
  output logic [NUM-1:0]                       in_rdy,
  input  logic [NUM*OP_W-1:0]                  in_op,
  input  logic [NUM*DSIZE-1:0]                 in_data,
  input  logic [NUM-1:0]                       in_last,
  output logic                                 out_vld,
  input  logic                                 out_rdy,
  output logic [OP_W+DSIZE+$clog2(NUM):0]      out_rec,
  output logic [$clog2(DEPTH):0]               fifo_cnt
);

  import rr_merge_pkg::*;

  localparam int CHW   = $clog2(NUM);
  localparam int REC_W = OP_W + DSIZE + CHW + 1;

  arb_st_t          state_q;
  logic [CHW-1:0]   rr_ptr_q;
  logic [CHW-1:0]   lock_ch_q;
  logic             grant_vld;
  logic [CHW-1:0]   grant_ch;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rec_last;
  logic [REC_W-1:0] rec_in;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    if (state_q == LOCK) begin
      grant_vld = in_vld[lock_ch_q];
      grant_ch  = lock_ch_q;
    end else begin
      for (int k = 0; k < NUM; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM) begin
          idx = idx - NUM;
        end
        if (!grant_vld && in_vld[idx]) begin
          grant_vld = 1'b1;
          grant_ch  = CHW'(idx);
        end
      end
    end
  end

  // Full blocks the push even when a pop coincides, keeping out_rdy off the in_rdy path.
  assign accept   = grant_vld && !fifo_full && !rst;
  assign rec_last = (PKT_MODE != 0) ? in_last[grant_ch] : 1'b1;
  assign rec_in   = {in_op[int'(grant_ch)*OP_W +: OP_W],
                     in_data[int'(grant_ch)*DSIZE +: DSIZE],
                     grant_ch, rec_last};

  always_comb begin
    in_rdy = '0;
    if (accept) begin
      in_rdy[grant_ch] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        rr_ptr_q <= CHW'(rr_next(32'(grant_ch), NUM));
        if ((PKT_MODE != 0) && !in_last[grant_ch]) begin
          state_q   <= LOCK;
          lock_ch_q <= grant_ch;
        end
      end else if (in_last[lock_ch_q]) begin
        state_q  <= IDLE;
        rr_ptr_q <= CHW'(rr_next(32'(lock_ch_q), NUM));
      end
    end
  end

  rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .push_i  (accept),
    .din_i   (rec_in),
    .pop_i   (out_vld && out_rdy),
    .dout_o  (out_rec),
    .cnt_o   (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_vld = !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_struct_rr_merge.sv
// +--------------------------------------------------------------------------+
// | tb_struct_rr_merge : vector table + scoreboard bench for struct_rr_merge |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_struct_rr_merge;

  import rr_merge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: NUM=5, PKT_MODE=0
  logic [4:0]  a_vld, a_rdy, a_last;
  logic [19:0] a_op;
  logic [49:0] a_data;
  logic        a_ovld, a_ordy;
  logic [17:0] a_rec;
  logic [2:0]  a_cnt;

  // Instance B: NUM=3, PKT_MODE=1
  logic [2:0]  b_vld, b_rdy, b_last;
  logic [11:0] b_op;
  logic [29:0] b_data;
  logic        b_ovld, b_ordy;
  logic [16:0] b_rec;
  logic [2:0]  b_cnt;

  struct_rr_merge #(.NUM(5), .DSIZE(10), .OP_W(4), .DEPTH(4), .PKT_MODE(0)) dut_a (
    .clock(clk), .rst(rst), .in_vld(a_vld), .in_rdy(a_rdy), .in_op(a_op),
    .in_data(a_data), .in_last(a_last), .out_vld(a_ovld), .out_rdy(a_ordy),
    .out_rec(a_rec), .fifo_cnt(a_cnt));

  struct_rr_merge #(.NUM(3), .DSIZE(10), .OP_W(4), .DEPTH(4), .PKT_MODE(1)) dut_b (
    .clock(clk), .rst(rst), .in_vld(b_vld), .in_rdy(b_rdy), .in_op(b_op),
    .in_data(b_data), .in_last(b_last), .out_vld(b_ovld), .out_rdy(b_ordy),
    .out_rec(b_rec), .fifo_cnt(b_cnt));

  int errors = 0;
  int checks = 0;
  rec_t        qa[$];
  logic [16:0] qb[$];

  typedef struct {
    logic [4:0] vld;
    logic       ordy;
    logic [4:0] rdy;
    logic [2:0] cnt;
  } vec_t;
  vec_t va[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] opv(input int s, input int i);
    return 4'(s + i * 3);
  endfunction

  function automatic logic [9:0] datav(input int s, input int i);
    return 10'(s * 8 + i);
  endfunction

  task automatic step_a(input int s, input vec_t v);
    rec_t e;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_op[i*4 +: 4]    = opv(s, i);
      a_data[i*10 +: 10] = datav(s, i);
    end
    a_last = 5'b00000;
    a_vld  = v.vld;
    a_ordy = v.ordy;
    #1;
    chk($sformatf("a_rdy[%0d]", s), 32'(a_rdy), 32'(v.rdy));
    chk($sformatf("a_cnt[%0d]", s), 32'(a_cnt), 32'(v.cnt));
    chk($sformatf("a_ovld[%0d]", s), 32'(a_ovld), 32'(v.cnt != 0));
    if (a_ovld && a_ordy) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_out: got %0h expected none", a_rec);
      end else begin
        e = qa.pop_front();
        chk($sformatf("a_rec[%0d]", s), 32'(a_rec), 32'(e));
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (v.rdy[i]) begin
        e.op   = opv(s, i);
        e.data = datav(s, i);
        e.ch   = 3'(i);
        e.last = 1'b1;
        qa.push_back(e);
      end
    end
  endtask

  task automatic step_b(input int s, input logic [2:0] vld, input logic [2:0] last,
                        input logic ordy, input logic [2:0] rdy, input logic [2:0] cnt);
    logic [16:0] e;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_op[i*4 +: 4]     = opv(s + 32, i);
      b_data[i*10 +: 10] = datav(s + 32, i);
    end
    b_vld  = vld;
    b_last = last;
    b_ordy = ordy;
    #1;
    chk($sformatf("b_rdy[%0d]", s), 32'(b_rdy), 32'(rdy));
    chk($sformatf("b_cnt[%0d]", s), 32'(b_cnt), 32'(cnt));
    chk($sformatf("b_ovld[%0d]", s), 32'(b_ovld), 32'(cnt != 0));
    if (b_ovld && b_ordy) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_out: got %0h expected none", b_rec);
      end else begin
        e = qb.pop_front();
        chk($sformatf("b_rec[%0d]", s), 32'(b_rec), 32'(e));
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (rdy[i]) begin
        qb.push_back({opv(s + 32, i), datav(s + 32, i), 2'(i), last[i]});
      end
    end
  endtask

  initial begin
    va[0]  = '{5'b11111, 1'b1, 5'b00001, 3'd0};
    va[1]  = '{5'b11111, 1'b1, 5'b00010, 3'd1};
    va[2]  = '{5'b11111, 1'b1, 5'b00100, 3'd1};
    va[3]  = '{5'b11111, 1'b1, 5'b01000, 3'd1};
    va[4]  = '{5'b11111, 1'b1, 5'b10000, 3'd1};
    va[5]  = '{5'b11111, 1'b1, 5'b00001, 3'd1};
    va[6]  = '{5'b10001, 1'b1, 5'b10000, 3'd1};
    va[7]  = '{5'b00000, 1'b1, 5'b00000, 3'd1};
    va[8]  = '{5'b01001, 1'b1, 5'b00001, 3'd0};
    va[9]  = '{5'b01000, 1'b1, 5'b01000, 3'd1};
    va[10] = '{5'b00110, 1'b1, 5'b00010, 3'd1};
    va[11] = '{5'b00101, 1'b1, 5'b00100, 3'd1};
    va[12] = '{5'b00001, 1'b1, 5'b00001, 3'd1};
    va[13] = '{5'b10000, 1'b1, 5'b10000, 3'd1};
    va[14] = '{5'b01000, 1'b1, 5'b01000, 3'd1};
    va[15] = '{5'b11000, 1'b1, 5'b10000, 3'd1};
    va[16] = '{5'b00000, 1'b1, 5'b00000, 3'd1};
    va[17] = '{5'b11111, 1'b0, 5'b00001, 3'd0};
    va[18] = '{5'b11111, 1'b0, 5'b00010, 3'd1};
    va[19] = '{5'b11111, 1'b0, 5'b00100, 3'd2};
    va[20] = '{5'b11111, 1'b0, 5'b01000, 3'd3};
    va[21] = '{5'b11111, 1'b0, 5'b00000, 3'd4};
    va[22] = '{5'b11111, 1'b1, 5'b00000, 3'd4};
    va[23] = '{5'b11111, 1'b1, 5'b10000, 3'd3};
    va[24] = '{5'b00000, 1'b1, 5'b00000, 3'd3};
    va[25] = '{5'b00000, 1'b1, 5'b00000, 3'd2};
    va[26] = '{5'b00000, 1'b1, 5'b00000, 3'd1};
    va[27] = '{5'b00000, 1'b1, 5'b00000, 3'd0};

    // Reset with every channel requesting: nothing may be accepted.
    rst    = 1'b1;
    a_vld  = 5'b11111; a_last = '0; a_op = '0; a_data = '0; a_ordy = 1'b0;
    b_vld  = 3'b111;   b_last = '0; b_op = '0; b_data = '0; b_ordy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rdy", 32'(a_rdy), 32'd0);
    chk("rst_a_ovld", 32'(a_ovld), 32'd0);
    chk("rst_a_rec", 32'(a_rec), 32'd0);
    chk("rst_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst_b_rdy", 32'(b_rdy), 32'd0);
    chk("rst_b_cnt", 32'(b_cnt), 32'd0);
    b_vld = 3'b000;

    for (int v = 0; v < 28; v++) begin
      step_a(v, va[v]);
    end
    a_vld = 5'b00000;

    // Wrap on NUM=3, then a 3-beat packet on ch1 with a stall mid-packet.
    step_b(0,  3'b100, 3'b111, 1'b1, 3'b100, 3'd0);
    step_b(1,  3'b111, 3'b111, 1'b1, 3'b001, 3'd1);
    step_b(2,  3'b110, 3'b101, 1'b1, 3'b010, 3'd1);
    step_b(3,  3'b111, 3'b101, 1'b1, 3'b010, 3'd1);
    step_b(4,  3'b101, 3'b101, 1'b1, 3'b000, 3'd1);
    step_b(5,  3'b110, 3'b111, 1'b1, 3'b010, 3'd0);
    step_b(6,  3'b111, 3'b111, 1'b1, 3'b100, 3'd1);
    step_b(7,  3'b000, 3'b111, 1'b1, 3'b000, 3'd1);
    // Build up LOCK on ch1 with three beats held in the FIFO.
    step_b(8,  3'b010, 3'b000, 1'b0, 3'b010, 3'd0);
    step_b(9,  3'b010, 3'b000, 1'b0, 3'b010, 3'd1);
    step_b(10, 3'b010, 3'b000, 1'b0, 3'b010, 3'd2);

    @(negedge clk);
    rst    = 1'b1;
    b_vld  = 3'b111;
    b_ordy = 1'b0;
    #1;
    chk("midrst_b_rdy", 32'(b_rdy), 32'd0);
    qb.delete();

    // After reset: lock gone, pointer back at 0, FIFO empty.
    step_b(11, 3'b101, 3'b111, 1'b1, 3'b001, 3'd0);
    step_b(12, 3'b000, 3'b111, 1'b1, 3'b000, 3'd1);
    step_b(13, 3'b000, 3'b111, 1'b1, 3'b000, 3'd0);

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/struct_rr_merge.md
# struct_rr_merge

Parametrised N-to-1 round-robin merger for record streams: collects `{op, data}` records from NUM valid/ready channels, tags each with its source channel, and buffers them in an output FIFO for a single downstream consumer. It generalises the fixed 5-channel, fixed-width record front end to arbitrary channel count, width and depth. It adds an optional packet-lock mode that keeps multi-beat packets contiguous. It sits between per-source record producers and a shared record pipeline.

## Interface
Parameters:
- NUM, 5, number of input channels (≥2)
- DSIZE, 10, data field width
- OP_W, 4, op field width
- DEPTH, 4, output FIFO depth; power of two, ≥2
- PKT_MODE, 0, 0 = re-arbitrate every beat; 1 = hold grant until `last`

Ports:
- clock  in  1  sole clock
- rst  in  1  reset; synchronous and active-high
- in_vld  in  NUM  per-channel valid
- in_rdy  out  NUM  per-channel ready
- in_op  in  NUM×OP_W  per-channel op
- in_data  in  NUM×DSIZE  per-channel data
- in_last  in  NUM  per-channel end-of-packet; ignored when PKT_MODE=0
- out_vld  out  1  FIFO head valid
- out_rdy  in  1  downstream ready
- out_rec  out  rec_t  head record {op, data, ch, last}
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Handshakes: a beat transfers when vld&rdy are both high on a rising edge. Valid must not depend on ready.
- Arbiter states: IDLE and LOCK. LOCK exists only when PKT_MODE=1.
- IDLE behaviour:
  - grant goes to the first requesting channel at or after `rr_ptr`, searching cyclically.
  - On acceptance, `rr_ptr` becomes (granted+1) mod NUM.
- IDLE → LOCK transition: PKT_MODE=1 and the accepted beat has last=0. `lock_ch` is set to the granted channel.
- LOCK behaviour:
  - Only `lock_ch` is eligible; other requests wait.
  - On an accepted beat with last=1, the block returns to IDLE and `rr_ptr` becomes (lock_ch+1) mod NUM.
- in_rdy[i]: high only when i is the granted channel, in_vld[i] is high, the FIFO is not full and rst is low. At most one bit is high.
- Record stored: {op=in_op[g], data=in_data[g], ch=g, last}. `last` is forced to 1 when PKT_MODE=0.
- FIFO:
  - Push on input acceptance; pop on out_vld&out_rdy.
  - Full is fifo_cnt==DEPTH. Push is blocked when full, even if a pop happens in the same cycle; this keeps in_rdy off the out_rdy path.
  - Simultaneous push and pop when not full leaves fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
- NUM is not required to be a power of two. The rr_ptr wrap is an explicit compare against NUM-1.

## Timing
- Reset values: in_rdy=0, out_vld=0, out_rec=0, fifo_cnt=0, state=IDLE, rr_ptr=0, lock_ch=0.
- Reset asserted mid-packet or with data in the FIFO discards all contents and the lock.
- Latency: a beat accepted at edge k appears at out_vld after edge k (registered FIFO head), when the FIFO was empty.
- Throughput: one beat per cycle sustained while out_rdy=1 and DEPTH≥2.
- The arbiter and grant are combinational from in_vld, state and rr_ptr. All state updates happen on the clock edge.
- A channel that drops in_vld while in LOCK simply stalls. Lock is kept until last=1 is accepted.

## Structure
- Package `rr_merge_pkg` holds:
  - parameters: NUM, DSIZE, OP_W, CH_W=$clog2(NUM)
  - `typedef struct packed {logic [OP_W-1:0] op; logic [DSIZE-1:0] data; logic [CH_W-1:0] ch; logic last;} rec_t`
  - `typedef enum logic {IDLE, LOCK} arb_st_t`
- One sub-module, `rec_fifo`: a synchronous FIFO of rec_t with DEPTH entries, plus count, full and empty.
- The arbiter and lock FSM sit in the top module.

## Test plan
- Reset, then all 5 channels valid with data=i, PKT_MODE=0, out_rdy=1 → out sequence ch 0,1,2,3,4,0…; one beat per cycle; first out_vld one cycle after first accept.
- Only ch3 valid after ch4 was last served → ch3 granted immediately; rr_ptr becomes 4.
- PKT_MODE=1: ch1 sends a 3-beat packet (last on beat 3) while ch2 is valid throughout → three ch1 records out contiguously, then ch2.
- out_rdy=0, DEPTH=4, continuous input → exactly 4 accepts, fifo_cnt=4, all in_rdy=0. Raise out_rdy → drain in order; in_rdy returns the cycle after fifo_cnt<4.
- Assert rst for one cycle mid-packet in LOCK with fifo_cnt=3 → next cycle out_vld=0, fifo_cnt=0, state IDLE, ch0 has priority.
- NUM=3 build: ch2 accepted → rr_ptr wraps to 0, no out-of-range grant.
